// File: rtl/rename_map.sv
// Register rename stage for a 4-wide decode group.
// Keeps a speculative RAT, an architectural RAT and a circular free list.
module rename_map #(
  parameter int NUM_PREG = 64,
  parameter int FL_DEPTH = 32
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [3:0][4:0]                       in_rd_idx,
  input  logic [3:0][4:0]                       in_rj_idx,
  input  logic [3:0][4:0]                       in_rk_idx,
  input  logic [3:0]                            in_rd_exist,
  input  logic [3:0]                            in_rj_exist,
  input  logic [3:0]                            in_rk_exist,
  input  logic [3:0][1:0]                       in_rj_raw_pos,
  input  logic [3:0][1:0]                       in_rk_raw_pos,
  input  logic [3:0][1:0]                       in_rd_waw_pos,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [3:0][$clog2(NUM_PREG)-1:0]      out_prd,
  output logic [3:0][$clog2(NUM_PREG)-1:0]      out_prj,
  output logic [3:0][$clog2(NUM_PREG)-1:0]      out_prk,
  output logic [3:0][$clog2(NUM_PREG)-1:0]      out_old_prd,
  input  logic [3:0]                            commit_valid,
  input  logic [3:0]                            commit_rd_exist,
  input  logic [3:0][4:0]                       commit_rd,
  input  logic [3:0][$clog2(NUM_PREG)-1:0]      commit_prd,
  input  logic [3:0][$clog2(NUM_PREG)-1:0]      commit_old_prd,
  input  logic                                  flush
);
  localparam int PRW = $clog2(NUM_PREG);
  localparam int AW  = $clog2(FL_DEPTH);
  localparam int PW  = AW + 1;

  logic [PRW-1:0] spec_rat [32];
  logic [PRW-1:0] arch_rat [32];
  logic [PRW-1:0] arch_nxt [32];
  logic [PRW-1:0] fl [FL_DEPTH];

  logic [PW-1:0] head, cmt_head, tail, free_cnt;
  logic [3:0] need, cm;
  logic [2:0] ncnt, ccnt;
  logic [AW-1:0] aidx [4];
  logic [AW-1:0] cidx [4];
  logic [3:0][PRW-1:0] prd, prj, prk, old_prd;
  logic accept;

  function automatic logic [PRW-1:0] pick(
    input logic                ex,
    input logic [4:0]          idx,
    input logic [1:0]          pos,
    input logic [1:0]          slot,
    input logic [3:0][PRW-1:0] grp,
    input logic [PRW-1:0]      rat
  );
    if (!ex || idx == 5'd0) return '0;
    if (pos != slot)        return grp[pos];
    return rat;
  endfunction

  assign free_cnt = tail - head;
  assign in_ready = !rst && !flush && (!out_valid || out_ready)
                    && free_cnt >= PW'(4);
  assign accept   = in_valid && in_ready;

  // Slot i takes the free-list entry after all older destination slots.
  always_comb begin
    ncnt = '0;
    need = '0;
    prd  = '0;
    for (int i = 0; i < 4; i++) begin
      need[i] = in_rd_exist[i] && in_rd_idx[i] != 5'd0;
      aidx[i] = head[AW-1:0] + AW'(ncnt);
      if (need[i]) prd[i] = fl[aidx[i]];
      ncnt = ncnt + {2'b00, need[i]};
    end
  end

  always_comb begin
    prj     = '0;
    prk     = '0;
    old_prd = '0;
    for (int i = 0; i < 4; i++) begin
      prj[i] = pick(in_rj_exist[i], in_rj_idx[i], in_rj_raw_pos[i],
                    2'(i), prd, spec_rat[in_rj_idx[i]]);
      prk[i] = pick(in_rk_exist[i], in_rk_idx[i], in_rk_raw_pos[i],
                    2'(i), prd, spec_rat[in_rk_idx[i]]);
      old_prd[i] = pick(need[i], in_rd_idx[i], in_rd_waw_pos[i],
                        2'(i), prd, spec_rat[in_rd_idx[i]]);
    end
  end

  // Post-commit architectural view, also the flush recovery source.
  always_comb begin
    ccnt     = '0;
    cm       = '0;
    arch_nxt = arch_rat;
    for (int i = 0; i < 4; i++) begin
      cm[i]   = commit_valid[i] && commit_rd_exist[i]
                && commit_rd[i] != 5'd0;
      cidx[i] = tail[AW-1:0] + AW'(ccnt);
      if (cm[i]) arch_nxt[commit_rd[i]] = commit_prd[i];
      ccnt = ccnt + {2'b00, cm[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) begin
        spec_rat[r] <= PRW'(r);
        arch_rat[r] <= PRW'(r);
      end
      for (int k = 0; k < FL_DEPTH; k++)
        fl[k] <= PRW'(NUM_PREG - FL_DEPTH + k);
      head     <= '0;
      cmt_head <= '0;
      tail     <= PW'(FL_DEPTH);
    end else begin
      arch_rat <= arch_nxt;
      for (int i = 0; i < 4; i++)
        if (cm[i]) fl[cidx[i]] <= commit_old_prd[i];
      tail     <= tail + PW'(ccnt);
      cmt_head <= cmt_head + PW'(ccnt);
      if (flush) begin
        spec_rat <= arch_nxt;
        head     <= cmt_head + PW'(ccnt);
      end else if (accept) begin
        for (int i = 0; i < 4; i++)
          if (need[i]) spec_rat[in_rd_idx[i]] <= prd[i];
        head <= head + PW'(ncnt);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_prd     <= '0;
      out_prj     <= '0;
      out_prk     <= '0;
      out_old_prd <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_prd     <= prd;
      out_prj     <= prj;
      out_prk     <= prk;
      out_old_prd <= old_prd;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule
